l1_dcache: RTL and testbench
============================

# l1_dcache

Two-way set-associative, write-back, write-allocate L1 data cache that sits directly downstream of the pipeline datapath's MEM-stage data port and upstream of physical memory. It answers the datapath's `mem_read`/`mem_write` requests with `d_mem_resp`. Hits return in the same cycle so `global_load` advances without a stall; misses hold `d_mem_resp` low while the block evicts and refills 128-bit lines over the `pmem_*` port.

## Interface
- `SET_BITS`, default 3: log2 of the number of sets. Tag width is 12 - `SET_BITS`.
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `mem_read`  in  1  datapath load request; held until `d_mem_resp`
- `mem_write`  in  1  datapath store request; held until `d_mem_resp`
- `mem_address`  in  16  byte address
- `mem_wdata`  in  16  store data, already byte-lane aligned
- `mem_byte_enable`  in  2  bit0 = low byte, bit1 = high byte
- `mem_rdata`  out  16  selected word of hit line
- `d_mem_resp`  out  1  request complete, combinational on hit
- `pmem_read`  out  1  line fill request
- `pmem_write`  out  1  line writeback request
- `pmem_address`  out  16  line address, bits [3:0] always 0
- `pmem_wdata`  out  128  victim line
- `pmem_rdata`  in  128  fill line
- `pmem_resp`  in  1  physical memory done; one-cycle pulse

## Operation
- Address split: tag = [15:4+`SET_BITS`], index = [3+`SET_BITS`:4], word = [3:1]. Bit [0] is ignored; byte alignment is the requester's job.
- Per set state: 2× {valid, dirty, tag, 128-bit data} plus 1 LRU bit. LRU names the way to evict.
- FSM states: `IDLE`, `WRITEBACK`, `ALLOCATE`.
- **IDLE**
  - Hit = request active and a valid way's tag matches.
  - On hit: `d_mem_resp`=1 combinationally, `mem_rdata` = word of the hit way, LRU ← other way.
  - Write hit: merge `mem_wdata` per `mem_byte_enable` into the word and set dirty, both at the clock edge.
  - On miss: the victim is the LRU way. Go to `WRITEBACK` if the victim is valid and dirty, else to `ALLOCATE`.
- **WRITEBACK**
  - Outputs: `pmem_write`=1, `pmem_address`={victim tag, index, 4'b0}, `pmem_wdata`=victim data.
  - On `pmem_resp`: go to `ALLOCATE`.
- **ALLOCATE**
  - Outputs: `pmem_read`=1, `pmem_address`={req tag, index, 4'b0}.
  - On `pmem_resp`: victim way ← `pmem_rdata`, tag written, valid=1, dirty=0. Go to `IDLE`, where the request then hits.
- Request priority: `mem_read` and `mem_write` both high is treated as a write.
- Request withdrawn mid-miss (e.g. pipeline flush): the current `WRITEBACK`/`ALLOCATE` still completes, then the FSM returns to `IDLE`. No CPU-visible effect.
- `pmem_resp` in `IDLE` is ignored.
- `mem_byte_enable`=00 on a write hit: responds, sets dirty, data unchanged.

## Timing
- Reset (async, `rst_n`=0):
  - state = `IDLE`; all valid, dirty and LRU bits = 0.
  - `d_mem_resp`, `pmem_read`, `pmem_write` = 0; `pmem_address` = 0.
  - Data and tag arrays are not reset.
- Reset mid-miss: the fill is abandoned immediately and the line is not written.
- Hit latency: 0 cycles (response in the request cycle).
- Clean miss: miss seen in cycle 0; `pmem_read` from cycle 1 through the `pmem_resp` cycle N; `d_mem_resp` in cycle N+1.
- Dirty miss: writeback adds its own span plus 0 extra cycles (`ALLOCATE` is entered the cycle after the writeback `pmem_resp`).
- `pmem_*` outputs are driven purely by state and the latched index/tag. The request address and victim way are latched at the miss edge, so `pmem_address` is stable even if `mem_address` changes.

## Structure
- Add to `lc3b_types`:
  - `lc3b_c_line` (128-bit)
  - `lc3b_c_tag`, `lc3b_c_index`, `lc3b_c_offset`
  - `dcache_state_t` enum
- Sub-module `dcache_way`: one way's valid/dirty/tag/data arrays, async read, byte-masked word write and full-line write. Instantiated twice.
- Top level holds the FSM, LRU array, hit logic and muxing.

## Test plan
- After reset, read 0x1234 → miss: `pmem_read` with `pmem_address`=0x1230; return line with word 2 = 0xBEEF → next cycle `d_mem_resp`=1, `mem_rdata`=0xBEEF.
- Repeat read 0x1234 → `d_mem_resp`=1 in the same cycle, no `pmem_*` activity.
- Write 0x00AA with byte_enable=01 to 0x1234 → hit, word becomes 0xBEAA; a re-read returns 0xBEAA.
- Fill 0x1230, 0x1A30, then 0x1C30 (same set, `SET_BITS`=3): dirty LRU way 0x1230 → `pmem_write` with address 0x1230 and word 2 = 0xBEAA, then `pmem_read` 0x1C30.
- Drop `mem_read` during `ALLOCATE` → fill completes, FSM returns to `IDLE`, no `d_mem_resp`.
- Assert `rst_n`=0 during `WRITEBACK` → `pmem_write` falls immediately; a subsequent read of any address misses.

Source files
------------

// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared types and line helpers for the l1 data cache
package lc3b_types;

  localparam int C_SET_BITS = 3;

  typedef logic [127:0]            lc3b_c_line;
  typedef logic [11-C_SET_BITS:0]  lc3b_c_tag;
  typedef logic [C_SET_BITS-1:0]   lc3b_c_index;
  typedef logic [2:0]              lc3b_c_offset;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } dcache_state_t;

  function automatic logic [15:0] get_word(input lc3b_c_line line, input lc3b_c_offset sel);
    return line[{sel, 4'b0000} +: 16];
  endfunction

  // Byte-lane merge of a 16-bit store into one word of a line.
  function automatic lc3b_c_line merge_word(input lc3b_c_line line, input lc3b_c_offset sel,
                                            input logic [15:0] wdata, input logic [1:0] be);
    lc3b_c_line r;
    r = line;
    if (be[0]) r[{sel, 4'b0000} +: 8] = wdata[7:0];
    if (be[1]) r[{sel, 4'b1000} +: 8] = wdata[15:8];
    return r;
  endfunction

endpackage

// File: rtl/dcache_way.sv
// rtl/dcache_way.sv - one cache way: valid/dirty/tag/data arrays, async read
module dcache_way
  import lc3b_types::*;
#(
  parameter int SET_BITS = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SET_BITS-1:0]  index_i,
  output logic                 valid_o,
  output logic                 dirty_o,
  output logic [11-SET_BITS:0] tag_o,
  output lc3b_c_line           data_o,
  input  logic                 word_we_i,
  input  lc3b_c_offset         word_sel_i,
  input  logic [15:0]          word_data_i,
  input  logic [1:0]           word_be_i,
  input  logic                 line_we_i,
  input  logic [11-SET_BITS:0] line_tag_i,
  input  lc3b_c_line           line_data_i
);

  localparam int NSETS = 1 << SET_BITS;

  logic [NSETS-1:0]     valid_q;
  logic [NSETS-1:0]     dirty_q;
  logic [11-SET_BITS:0] tag_q  [NSETS];
  lc3b_c_line           data_q [NSETS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we_i) begin
      valid_q[index_i] <= 1'b1;
      dirty_q[index_i] <= 1'b0;
    end else if (word_we_i) begin
      dirty_q[index_i] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; valid gates every use.
  always_ff @(posedge clk) begin
    if (line_we_i) begin
      tag_q[index_i]  <= line_tag_i;
      data_q[index_i] <= line_data_i;
    end else if (word_we_i) begin
      data_q[index_i] <= merge_word(data_q[index_i], word_sel_i, word_data_i, word_be_i);
    end
  end

  assign valid_o = valid_q[index_i];
  assign dirty_o = dirty_q[index_i];
  assign tag_o   = tag_q[index_i];
  assign data_o  = data_q[index_i];

endmodule

// File: rtl/l1_dcache.sv
// rtl/l1_dcache.sv - two-way set-associative write-back write-allocate L1 data cache
module l1_dcache
  import lc3b_types::*;
#(
  parameter int SET_BITS = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [15:0]   mem_address,
  input  logic [15:0]   mem_wdata,
  input  logic [1:0]    mem_byte_enable,
  output logic [15:0]   mem_rdata,
  output logic          d_mem_resp,
  output logic          pmem_read,
  output logic          pmem_write,
  output logic [15:0]   pmem_address,
  output logic [127:0]  pmem_wdata,
  input  logic [127:0]  pmem_rdata,
  input  logic          pmem_resp
);

  localparam int TAG_W = 12 - SET_BITS;
  localparam int NSETS = 1 << SET_BITS;

  dcache_state_t        state_q;
  logic [SET_BITS-1:0]  idx_q;
  logic [TAG_W-1:0]     tag_q;
  logic                 way_q;
  logic [NSETS-1:0]     lru_q;
  logic                 pmem_read_q;
  logic                 pmem_write_q;
  logic [15:0]          pmem_addr_q;

  logic [TAG_W-1:0]     req_tag;
  logic [SET_BITS-1:0]  req_idx;
  lc3b_c_offset         req_word;
  logic                 req;
  logic                 addr_unused;

  assign req_tag     = mem_address[15:4+SET_BITS];
  assign req_idx     = mem_address[3+SET_BITS:4];
  assign req_word    = mem_address[3:1];
  assign req         = mem_read | mem_write;
  assign addr_unused = mem_address[0];

  logic [SET_BITS-1:0]  cache_idx;
  logic [1:0]           way_valid;
  logic [1:0]           way_dirty;
  logic [TAG_W-1:0]     way_tag  [2];
  lc3b_c_line           way_data [2];
  logic [1:0]           word_we;
  logic [1:0]           line_we;

  // Outside IDLE the arrays are addressed by the latched miss index.
  assign cache_idx = (state_q == IDLE) ? req_idx : idx_q;

  for (genvar w = 0; w < 2; w++) begin : g_way
    dcache_way #(.SET_BITS(SET_BITS)) u_way (
      .clk         (clk),
      .rst_n       (rst_n),
      .index_i     (cache_idx),
      .valid_o     (way_valid[w]),
      .dirty_o     (way_dirty[w]),
      .tag_o       (way_tag[w]),
      .data_o      (way_data[w]),
      .word_we_i   (word_we[w]),
      .word_sel_i  (req_word),
      .word_data_i (mem_wdata),
      .word_be_i   (mem_byte_enable),
      .line_we_i   (line_we[w]),
      .line_tag_i  (tag_q),
      .line_data_i (pmem_rdata)
    );
  end

  logic hit0, hit1, hit, hit_way, victim;

  assign hit0    = way_valid[0] && (way_tag[0] == req_tag);
  assign hit1    = way_valid[1] && (way_tag[1] == req_tag);
  assign hit     = (state_q == IDLE) && req && (hit0 || hit1);
  assign hit_way = ~hit0;
  assign victim  = lru_q[req_idx];

  always_comb begin
    word_we          = '0;
    line_we          = '0;
    word_we[hit_way] = hit && mem_write;
    line_we[way_q]   = (state_q == ALLOCATE) && pmem_resp;
  end

  assign d_mem_resp   = hit;
  assign mem_rdata    = get_word(way_data[hit_way], req_word);
  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_addr_q;
  assign pmem_wdata   = way_data[way_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      tag_q        <= '0;
      way_q        <= 1'b0;
      lru_q        <= '0;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      pmem_addr_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hit) begin
            lru_q[req_idx] <= ~hit_way;
          end else if (req) begin
            idx_q <= req_idx;
            tag_q <= req_tag;
            way_q <= victim;
            if (way_valid[victim] && way_dirty[victim]) begin
              state_q      <= WRITEBACK;
              pmem_write_q <= 1'b1;
              pmem_addr_q  <= {way_tag[victim], req_idx, 4'b0000};
            end else begin
              state_q     <= ALLOCATE;
              pmem_read_q <= 1'b1;
              pmem_addr_q <= {req_tag, req_idx, 4'b0000};
            end
          end
        end
        WRITEBACK: begin
          if (pmem_resp) begin
            state_q      <= ALLOCATE;
            pmem_write_q <= 1'b0;
            pmem_read_q  <= 1'b1;
            pmem_addr_q  <= {tag_q, idx_q, 4'b0000};
          end
        end
        ALLOCATE: begin
          if (pmem_resp) begin
            state_q     <= IDLE;
            pmem_read_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          pmem_read_q  <= 1'b0;
          pmem_write_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l1_dcache.sv
// tb/tb_l1_dcache.sv - scoreboard bench for l1_dcache with a latency-3 memory model
module tb_l1_dcache;

  logic          clk;
  logic          rst_n;
  logic          mem_read;
  logic          mem_write;
  logic [15:0]   mem_address;
  logic [15:0]   mem_wdata;
  logic [1:0]    mem_byte_enable;
  logic [15:0]   mem_rdata;
  logic          d_mem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [15:0]   pmem_address;
  logic [127:0]  pmem_wdata;
  logic [127:0]  pmem_rdata;
  logic          pmem_resp;

  l1_dcache #(.SET_BITS(3)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .mem_rdata       (mem_rdata),
    .d_mem_resp      (d_mem_resp),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_address    (pmem_address),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic chk; logic [15:0] data; } resp_exp_t;
  typedef struct packed { logic wr; logic [15:0] addr; logic [15:0] w2; } pmem_exp_t;

  resp_exp_t      rq [$];
  pmem_exp_t      pq [$];
  logic [127:0]   mem [logic [15:0]];
  int             checks = 0;
  int             errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Untouched lines hold word k = line address + k.
  function automatic logic [127:0] mem_line(input logic [15:0] a);
    logic [127:0] l;
    if (mem.exists(a)) return mem[a];
    for (int k = 0; k < 8; k++) l[k*16 +: 16] = a + 16'(k);
    return l;
  endfunction

  initial begin
    int lat;
    lat = 0;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      pmem_resp = 1'b0;
      if (!rst_n) lat = 0;
      else if (pmem_read || pmem_write) begin
        lat++;
        if (lat == 3) begin
          if (pmem_write) mem[pmem_address] = pmem_wdata;
          else pmem_rdata = mem_line(pmem_address);
          pmem_resp = 1'b1;
          lat = 0;
        end
      end else lat = 0;
    end
  end

  initial begin
    logic in_txn;
    resp_exp_t e;
    pmem_exp_t p;
    in_txn = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) in_txn = 1'b0;
      else begin
        if (d_mem_resp) begin
          if (rq.size() == 0) begin
            checks++; errors++;
            $display("FAIL resp_unexpected: got d_mem_resp=1 addr 0x%0h expected none", mem_address);
          end else begin
            e = rq.pop_front();
            if (e.chk) chk("mem_rdata", 128'(mem_rdata), 128'(e.data));
          end
        end
        if ((pmem_read || pmem_write) && !in_txn) begin
          in_txn = 1'b1;
          if (pq.size() == 0) begin
            checks++; errors++;
            $display("FAIL pmem_unexpected: got rd=%0b wr=%0b addr 0x%0h expected none",
                     pmem_read, pmem_write, pmem_address);
          end else begin
            p = pq.pop_front();
            chk("pmem_write", 128'(pmem_write), 128'(p.wr));
            chk("pmem_read", 128'(pmem_read), 128'(!p.wr));
            chk("pmem_address", 128'(pmem_address), 128'(p.addr));
            if (p.wr) chk("pmem_wdata_word2", 128'(pmem_wdata[47:32]), 128'(p.w2));
          end
        end
        if (pmem_resp) in_txn = 1'b0;
      end
    end
  end

  task automatic req(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] wd,
                     input logic [1:0] be, input logic chk_d, input logic [15:0] exp_d, input int exp_lat);
    int   lat;
    logic got;
    rq.push_back('{chk_d, exp_d});
    mem_read = rd; mem_write = wr; mem_address = a; mem_wdata = wd; mem_byte_enable = be;
    lat = 0; got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      if (d_mem_resp) got = 1'b1;
      else lat++;
    end
    chk($sformatf("latency@%h", a), 128'(got ? lat : -1), 128'(exp_lat));
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 expected earlier finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] l;
    l = mem_line(16'h1230);
    l[47:32] = 16'hBEEF;
    mem[16'h1230] = l;
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    mem_address = '0; mem_wdata = '0; mem_byte_enable = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_resp", 128'(d_mem_resp), 128'(0));
    chk("reset_pmem_read", 128'(pmem_read), 128'(0));
    chk("reset_pmem_write", 128'(pmem_write), 128'(0));
    chk("reset_pmem_address", 128'(pmem_address), 128'(0));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    pq.push_back('{1'b0, 16'h1230, 16'h0});
    req(1, 0, 16'h1234, 16'h0, 2'b00, 1, 16'hBEEF, 4);
    req(1, 0, 16'h1234, 16'h0, 2'b00, 1, 16'hBEEF, 0);
    req(0, 1, 16'h1234, 16'h00AA, 2'b01, 0, 16'h0, 0);
    req(1, 0, 16'h1234, 16'h0, 2'b00, 1, 16'hBEAA, 0);
    pq.push_back('{1'b0, 16'h1A30, 16'h0});
    req(1, 0, 16'h1A34, 16'h0, 2'b00, 1, 16'h1A32, 4);
    pq.push_back('{1'b1, 16'h1230, 16'hBEAA});
    pq.push_back('{1'b0, 16'h1C30, 16'h0});
    req(1, 0, 16'h1C38, 16'h0, 2'b00, 1, 16'h1C34, 7);
    req(0, 1, 16'h1C38, 16'h5566, 2'b10, 0, 16'h0, 0);
    req(1, 0, 16'h1C38, 16'h0, 2'b00, 1, 16'h5534, 0);
    req(0, 1, 16'h1C38, 16'hFFFF, 2'b00, 0, 16'h0, 0);
    req(1, 0, 16'h1C38, 16'h0, 2'b00, 1, 16'h5534, 0);
    req(1, 1, 16'h1C38, 16'h0077, 2'b01, 0, 16'h0, 0);
    req(1, 0, 16'h1C38, 16'h0, 2'b00, 1, 16'h5577, 0);
    pq.push_back('{1'b0, 16'h1230, 16'h0});
    req(1, 0, 16'h1234, 16'h0, 2'b00, 1, 16'hBEAA, 4);
    req(1, 0, 16'h1C38, 16'h0, 2'b00, 1, 16'h5577, 0);

    // Request withdrawn while the fill is in flight.
    pq.push_back('{1'b0, 16'h2230, 16'h0});
    mem_read = 1'b1; mem_address = 16'h2234;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_read = 1'b0; mem_address = 16'h0000;
    repeat (8) @(posedge clk);
    #1;
    chk("drop_fill_done", 128'(pmem_read), 128'(0));
    req(1, 0, 16'h2234, 16'h0, 2'b00, 1, 16'h2232, 0);

    // Reset in the middle of a writeback.
    pq.push_back('{1'b1, 16'h1C30, 16'h1C32});
    mem_read = 1'b1; mem_address = 16'h3234;
    @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b0; mem_read = 1'b0;
    #1;
    chk("rst_mid_pmem_write", 128'(pmem_write), 128'(0));
    chk("rst_mid_pmem_read", 128'(pmem_read), 128'(0));
    chk("rst_mid_pmem_address", 128'(pmem_address), 128'(0));
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    pq.push_back('{1'b0, 16'h2230, 16'h0});
    req(1, 0, 16'h2234, 16'h0, 2'b00, 1, 16'h2232, 4);
    pq.push_back('{1'b0, 16'h1230, 16'h0});
    req(1, 0, 16'h1234, 16'h0, 2'b00, 1, 16'hBEAA, 4);

    repeat (2) @(posedge clk);
    chk("resp_queue_empty", 128'(rq.size()), 128'(0));
    chk("pmem_queue_empty", 128'(pq.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
